// File: rtl/can_pkg.sv
// Shared CAN CRC definitions: default CRC-15 polynomial, transmit FSM states
// and the single-bit CRC update used by both transmitter and receiver checker.
package can_pkg;

    localparam int          CAN_CRC_W    = 15;
    localparam logic [14:0] CAN_CRC_POLY = 15'h4599;

    typedef enum logic {IDLE, RUN} state_t;

    // Width-generic step on a 16-bit container; bits above w stay zero.
    function automatic logic [15:0] crc_step_w(input logic [15:0] crc, input logic d,
                                               input int w, input logic [15:0] poly);
        logic [15:0] mask;
        logic [15:0] nxt_crc;
        logic        nxt;
        mask    = 16'((17'h1 << w) - 17'h1);
        nxt     = d ^ crc[4'(w - 1)];
        nxt_crc = (crc << 1) & mask;
        if (nxt)
            nxt_crc = nxt_crc ^ (poly & mask);
        return nxt_crc;
    endfunction

    function automatic logic [CAN_CRC_W-1:0] crc_step(input logic [CAN_CRC_W-1:0] crc,
                                                      input logic d);
        logic [15:0] full;
        full = crc_step_w({1'b0, crc}, d, CAN_CRC_W, {1'b0, CAN_CRC_POLY});
        return full[CAN_CRC_W-1:0];
    endfunction

endpackage

// File: rtl/lpset6_crc.sv
// Bit-serial CRC generator for the CAN transmitter: absorbs one bit per clock
// while start is high, pulses done and holds the remainder on r when it drops.
module lpset6_crc
    import can_pkg::*;
#(
    parameter int               CRC_W    = CAN_CRC_W,
    parameter logic [CRC_W-1:0] POLY     = CAN_CRC_POLY,
    parameter logic [CRC_W-1:0] INIT     = '0,
    parameter int               MAX_BITS = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        data,
    output logic        done,
    output logic [15:0] r
);

    localparam int               CNT_W   = $clog2(MAX_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BITS);
    localparam logic [15:0]      POLY_X  = 16'(POLY);
    localparam logic [15:0]      INIT_X  = 16'(INIT);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      crc_q;
    logic             blk;
    logic [15:0]      step_in;
    logic [15:0]      crc_nxt;

    // The first bit of a frame is folded into INIT rather than the held remainder.
    assign step_in = (state == IDLE) ? INIT_X : crc_q;
    assign crc_nxt = crc_step_w(step_in, data, CRC_W, POLY_X);
    assign r       = crc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            crc_q <= '0;
            done  <= 1'b0;
            blk   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !blk) begin
                        crc_q <= crc_nxt;
                        cnt   <= CNT_W'(1);
                        state <= RUN;
                    end
                    if (!start)
                        blk <= 1'b0;
                end
                RUN: begin
                    done <= 1'b0;
                    if (!start) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (cnt < CNT_MAX) begin
                        crc_q <= crc_nxt;
                        cnt   <= cnt + 1'b1;
                    end else begin
                        // Frame length exhausted: finish, and refuse to restart
                        // until start has been seen low.
                        done  <= 1'b1;
                        blk   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lpset6_crc.sv
// Self-checking bench for lpset6_crc: a default instance and a MAX_BITS=8
// instance, each checked every cycle against a polynomial-remainder model.
module tb_lpset6_crc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0, data0 = 1'b0, done0;
    logic        start1 = 1'b0, data1 = 1'b0, done1;
    logic [15:0] r0, r1;

    int checks = 0;
    int errors = 0;

    lpset6_crc dut0 (.clk(clk), .rst(rst), .start(start0), .data(data0), .done(done0), .r(r0));
    lpset6_crc #(.MAX_BITS(8)) dut1 (.clk(clk), .rst(rst), .start(start1), .data(data1),
                                     .done(done1), .r(r1));

    always #5 clk = ~clk;

    // x^k mod G for G = x^15 + 0x4599
    logic [15:0] pw [0:160];

    // Remainder of M(x)*x^15 mod G, built as a sum of per-bit monomial residues.
    function automatic logic [15:0] golden(input logic [127:0] b, input int n);
        logic [15:0] acc;
        acc = '0;
        for (int i = 0; i < n; i++)
            if (b[i]) acc = acc ^ pw[15 + n - 1 - i];
        return acc;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model state
    int           m_n    [2];
    logic [127:0] m_bits [2];
    bit           m_act  [2];
    bit           m_blk  [2];
    logic [15:0]  m_r    [2];
    logic         m_done [2];
    int           maxb   [2] = '{127, 8};

    initial begin
        logic [15:0] v;
        logic [1:0]  s, d;
        pw[0] = 16'h0001;
        for (int k = 1; k <= 160; k++) begin
            v = pw[k-1] << 1;
            if (v[15]) v = v ^ 16'hC599;
            pw[k] = v;
        end
        forever begin
            @(posedge clk or posedge rst);
            s = {start1, start0};
            d = {data1, data0};
            for (int id = 0; id < 2; id++) begin
                if (rst) begin
                    m_n[id] = 0; m_bits[id] = '0; m_act[id] = 0; m_blk[id] = 0;
                    m_r[id] = '0; m_done[id] = 1'b0;
                end else begin
                    m_done[id] = 1'b0;
                    if (!m_act[id]) begin
                        if (s[id] && !m_blk[id]) begin
                            m_bits[id] = '0;
                            m_bits[id][0] = d[id];
                            m_n[id] = 1;
                            m_act[id] = 1;
                            m_r[id] = golden(m_bits[id], 1);
                        end
                        if (!s[id]) m_blk[id] = 0;
                    end else if (!s[id]) begin
                        m_done[id] = 1'b1;
                        m_act[id] = 0;
                    end else if (m_n[id] < maxb[id]) begin
                        m_bits[id][m_n[id]] = d[id];
                        m_n[id]++;
                        m_r[id] = golden(m_bits[id], m_n[id]);
                    end else begin
                        m_done[id] = 1'b1;
                        m_act[id] = 0;
                        m_blk[id] = 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("r0_model", r0, m_r[0]);
            chk("done0_model", {15'd0, done0}, {15'd0, m_done[0]});
            chk("r1_model", r1, m_r[1]);
            chk("done1_model", {15'd0, done1}, {15'd0, m_done[1]});
        end
    end

    task automatic set_in(input int id, input logic s, input logic d);
        if (id == 0) begin start0 = s; data0 = d; end
        else begin start1 = s; data1 = d; end
    endtask

    task automatic drive_frame(input int id, input logic [127:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
            set_in(id, 1'b1, b[i]);
        end
        @(posedge clk); #2;
        set_in(id, 1'b0, 1'b0);
    endtask

    task automatic expect_done(input logic [15:0] exp, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            if (done0) seen = 1;
        end
        if (seen) chk(name, r0, exp);
        else begin
            checks++; errors++;
            $display("FAIL %s: done never seen within 4 cycles", name);
        end
    endtask

    initial begin
        logic [127:0] b;
        int           pulses;
        logic [15:0]  rcap;

        // Model pinned by hand-computed remainders
        #1;
        chk("model_1", golden(128'h1, 1), 16'h4599);
        chk("model_10", golden(128'h1, 2), 16'h4EAB);
        chk("model_01", golden(128'h2, 2), 16'h4599);
        chk("model_zero19", golden(128'h0, 19), 16'h0000);

        repeat (3) @(posedge clk);
        #2;
        chk("reset_r", r0, 16'h0000);
        chk("reset_done", {15'd0, done0}, 16'h0000);
        rst = 1'b0;

        drive_frame(0, 128'h1, 1);
        expect_done(16'h4599, "single_1");
        drive_frame(0, 128'h0, 1);
        expect_done(16'h0000, "single_0");
        drive_frame(0, 128'h1, 2);
        expect_done(16'h4EAB, "two_10");
        drive_frame(0, 128'h2, 2);
        expect_done(16'h4599, "two_01");
        drive_frame(0, 128'h0, 19);
        expect_done(16'h0000, "zero19");
        @(negedge clk);
        chk("zero19_done_width", {15'd0, done0}, 16'h0000);

        // Back-to-back: "1,0", one idle cycle, "1"
        @(posedge clk); #2; set_in(0, 1'b1, 1'b1);
        @(posedge clk); #2; set_in(0, 1'b1, 1'b0);
        @(posedge clk); #2; set_in(0, 1'b0, 1'b0);
        @(posedge clk); #2; set_in(0, 1'b1, 1'b1);
        @(negedge clk);
        chk("b2b_done1", {15'd0, done0}, 16'h0001);
        chk("b2b_r1", r0, 16'h4EAB);
        @(posedge clk); #2; set_in(0, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_gap", {15'd0, done0}, 16'h0000);
        @(negedge clk);
        chk("b2b_done2", {15'd0, done0}, 16'h0001);
        chk("b2b_r2", r0, 16'h4599);

        // Reset mid-frame after 5 bits
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2; set_in(0, 1'b1, 1'($urandom_range(0, 1)));
        end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("midrst_r", r0, 16'h0000);
        chk("midrst_done", {15'd0, done0}, 16'h0000);
        set_in(0, 1'b0, 1'b0);
        @(negedge clk); rst = 1'b0;
        pulses = 0;
        repeat (5) begin @(negedge clk); if (done0) pulses++; end
        chk("midrst_no_done", 16'(pulses), 16'd0);

        // MAX_BITS=8 instance, start held 12 cycles
        b = '0;
        pulses = 0;
        rcap = '0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #2;
            b[i] = 1'($urandom_range(0, 1));
            set_in(1, 1'b1, b[i]);
            @(negedge clk);
            if (done1) begin pulses++; rcap = r1; end
        end
        chk("max8_pulses", 16'(pulses), 16'd1);
        chk("max8_r", rcap, golden(b, 8));
        chk("max8_held", r1, golden(b, 8));
        @(posedge clk); #2; set_in(1, 1'b0, 1'b0);
        @(posedge clk); #2; set_in(1, 1'b1, 1'b1);
        @(posedge clk); #2; set_in(1, 1'b0, 1'b0);
        @(negedge clk);
        chk("max8_rearm", r1, 16'h4599);

        // Long frame on the default instance crosses MAX_BITS=127
        for (int i = 0; i < 135; i++) begin
            @(posedge clk); #2; set_in(0, 1'b1, 1'($urandom_range(0, 1)));
        end
        @(posedge clk); #2; set_in(0, 1'b0, 1'b0);

        // Randomized bursts on both instances
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #2;
            set_in(0, ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)));
            set_in(1, ($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)));
        end
        @(posedge clk); #2;
        set_in(0, 1'b0, 1'b0);
        set_in(1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
